// File: rtl/rv_writeback_pkg.sv
// Shared widths, load funct3 encodings and the load-buffer entry type for the writeback stage.
package rv_writeback_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]   xdata_t;

   typedef struct packed {
      reg_addr_t rd;
      xdata_t    data;
   } wb_entry_t;

   function automatic logic [31:0] reg_onehot(input reg_addr_t rd);
      return 32'b1 << rd;
   endfunction

endpackage

// File: rtl/rv_writeback_if.sv
// Bundle of the EX/LSU-facing inputs and the regfile/scoreboard outputs of the writeback stage.
interface rv_writeback_if;
   import rv_writeback_pkg::*;

   logic        alu_valid;
   reg_addr_t   alu_rd;
   xdata_t      alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   reg_addr_t   lsu_rd;
   logic [2:0]  lsu_funct3;
   logic [1:0]  lsu_addr_lo;
   xdata_t      lsu_rdata;
   logic        issue_valid;
   reg_addr_t   issue_rd;
   logic        we;
   reg_addr_t   rd_a;
   xdata_t      rd_dt;
   logic [31:0] busy;
   logic        err_funct3;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output lsu_valid, lsu_rd, lsu_funct3, lsu_addr_lo, lsu_rdata,
      output issue_valid, issue_rd,
      input  lsu_ready, we, rd_a, rd_dt, busy, err_funct3
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  lsu_valid, lsu_rd, lsu_funct3, lsu_addr_lo, lsu_rdata,
      input  issue_valid, issue_rd,
      output lsu_ready, we, rd_a, rd_dt, busy, err_funct3
   );

endinterface

// File: rtl/rv_writeback_load_ext.sv
// Combinational load extender: picks the byte/half lane by address offset and sign/zero-extends.
module rv_load_ext
   import rv_writeback_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [1:0] addr_lo,
   input  xdata_t     rdata,
   output xdata_t     data,
   output logic       illegal
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Halfword lane ignores addr_lo[0]; misaligned halves are not split across lanes.
   assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
   assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      data    = '0;
      illegal = 1'b0;
      unique case (funct3)
         F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
         F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
         F3_LW:   data = rdata;
         F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
         F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/rv_writeback.sv
// Regfile write-port master: ALU results win the port, loads are buffered behind them,
// and a per-register scoreboard tracks loads still in flight.
module rv_writeback
   import rv_writeback_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2
)(
   input logic           clk,
   input logic           rest,
   rv_writeback_if.slave wb
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   wb_entry_t          fifo_mem [FIFO_DEPTH];
   logic [PW-1:0]      head;
   logic [PW-1:0]      tail;
   logic [CW-1:0]      count;

   xdata_t             ext_data;
   logic               ext_illegal;
   wb_entry_t          lsu_entry;
   logic               accept;

   logic               sel_valid;
   logic               sel_load;
   wb_entry_t          sel_entry;
   logic               enq;
   logic               deq;
   logic [31:0]        set_vec;
   logic [31:0]        clr_vec;

   logic               we_q;
   reg_addr_t          rd_a_q;
   xdata_t             rd_dt_q;
   logic [31:0]        busy_q;
   logic               err_q;

   rv_load_ext u_ext (
      .funct3  (wb.lsu_funct3),
      .addr_lo (wb.lsu_addr_lo),
      .rdata   (wb.lsu_rdata),
      .data    (ext_data),
      .illegal (ext_illegal)
   );

   assign wb.lsu_ready = (count < CW'(FIFO_DEPTH)) & ~rest;
   assign accept       = wb.lsu_valid & wb.lsu_ready;
   assign lsu_entry    = '{rd: wb.lsu_rd, data: ext_data};

   // Port priority: ALU, then oldest buffered load, then a bypassing load when the buffer is empty.
   always_comb begin
      sel_valid = 1'b0;
      sel_load  = 1'b0;
      sel_entry = '0;
      enq       = 1'b0;
      deq       = 1'b0;
      if (wb.alu_valid) begin
         sel_valid = 1'b1;
         sel_entry = '{rd: wb.alu_rd, data: wb.alu_data};
         enq       = accept;
      end else if (count != '0) begin
         sel_valid = 1'b1;
         sel_load  = 1'b1;
         sel_entry = fifo_mem[head];
         deq       = 1'b1;
         enq       = accept;
      end else if (accept) begin
         sel_valid = 1'b1;
         sel_load  = 1'b1;
         sel_entry = lsu_entry;
      end
   end

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (wb.issue_valid && (wb.issue_rd != '0))
         set_vec = reg_onehot(wb.issue_rd);
      if (sel_load)
         clr_vec = reg_onehot(sel_entry.rd);
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) begin
            fifo_mem[tail] <= lsu_entry;
            tail           <= tail + 1'b1;
         end
         if (deq)
            head <= head + 1'b1;
         if (enq && !deq)
            count <= count + 1'b1;
         else if (deq && !enq)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rest) begin
         we_q    <= 1'b0;
         rd_a_q  <= '0;
         rd_dt_q <= '0;
         busy_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         we_q <= sel_valid & (sel_entry.rd != '0);
         if (sel_valid) begin
            rd_a_q  <= sel_entry.rd;
            rd_dt_q <= sel_entry.data;
         end
         // A new issue to the register whose load is landing this edge must stay pending.
         busy_q <= (busy_q & ~clr_vec) | set_vec;
         err_q  <= accept & ext_illegal;
      end
   end

   assign wb.we         = we_q;
   assign wb.rd_a       = rd_a_q;
   assign wb.rd_dt      = rd_dt_q;
   assign wb.busy       = busy_q;
   assign wb.err_funct3 = err_q;

endmodule

// File: tb/tb_rv_writeback.sv
// Directed and random checks of rv_writeback against a queue-based model of the write port.
module tb_rv_writeback;

   localparam int DEPTH = 2;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic clk = 1'b0;
   logic rest;
   int   vectors = 0;
   int   errors  = 0;

   ent_t        q[$];
   logic [31:0] mbusy;
   bit          merr;

   rv_writeback_if bus ();

   rv_writeback #(.FIFO_DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rest (rest),
      .wb   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_ext(input logic [2:0] f3, input logic [1:0] lo,
                                   input logic [31:0] w, output logic [31:0] d, output bit ill);
      logic [31:0] b;
      logic [31:0] h;
      byte         sb;
      shortint     sh;
      b   = w >> (8 * lo);
      h   = w >> (16 * lo[1]);
      sb  = b[7:0];
      sh  = h[15:0];
      d   = 32'd0;
      ill = 1'b0;
      case (f3)
         3'd0:    d = 32'(int'(sb));
         3'd1:    d = 32'(int'(sh));
         3'd2:    d = w;
         3'd4:    d = b & 32'hFF;
         3'd5:    d = h & 32'hFFFF;
         default: ill = 1'b1;
      endcase
   endfunction

   task automatic idle();
      bus.alu_valid   = 1'b0;
      bus.alu_rd      = '0;
      bus.alu_data    = '0;
      bus.lsu_valid   = 1'b0;
      bus.lsu_rd      = '0;
      bus.lsu_funct3  = '0;
      bus.lsu_addr_lo = '0;
      bus.lsu_rdata   = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
   endtask

   // One clock: check ready, advance the model, then check the registered outputs.
   task automatic step(output bit accepted);
      logic [31:0] d;
      bit          ill, ready, ew, ldw, in_rst;
      logic [4:0]  erd;
      logic [31:0] edt;
      ent_t        e, h;
      #1;
      in_rst = rest;
      ready  = !rest && (q.size() < DEPTH);
      chk("lsu_ready", 32'(bus.lsu_ready), 32'(ready));
      accepted = bus.lsu_valid && ready;
      ref_ext(bus.lsu_funct3, bus.lsu_addr_lo, bus.lsu_rdata, d, ill);
      e.rd = bus.lsu_rd;
      e.data = d;
      ew = 0; ldw = 0; erd = '0; edt = '0;
      if (in_rst) begin
         q.delete();
         mbusy = '0;
         merr  = 0;
      end else begin
         if (bus.alu_valid) begin
            ew = 1; erd = bus.alu_rd; edt = bus.alu_data;
            if (accepted) q.push_back(e);
         end else if (q.size() > 0) begin
            h = q.pop_front();
            ew = 1; ldw = 1; erd = h.rd; edt = h.data;
            if (accepted) q.push_back(e);
         end else if (accepted) begin
            ew = 1; ldw = 1; erd = e.rd; edt = e.data;
         end
         if (ldw) mbusy[erd] = 1'b0;
         if (bus.issue_valid && bus.issue_rd != 0) mbusy[bus.issue_rd] = 1'b1;
         merr = accepted && ill;
      end
      @(posedge clk);
      #1;
      chk("we", 32'(bus.we), 32'(ew && erd != 0));
      if (in_rst) begin
         chk("rst_rd_a", 32'(bus.rd_a), 32'd0);
         chk("rst_rd_dt", bus.rd_dt, 32'd0);
      end else if (ew && erd != 0) begin
         chk("rd_a", 32'(bus.rd_a), 32'(erd));
         chk("rd_dt", bus.rd_dt, edt);
      end
      chk("busy", bus.busy, mbusy);
      chk("err_funct3", 32'(bus.err_funct3), 32'(merr));
   endtask

   task automatic load(input logic [4:0] rd, input logic [2:0] f3,
                       input logic [1:0] lo, input logic [31:0] w);
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd      = rd;
      bus.lsu_funct3  = f3;
      bus.lsu_addr_lo = lo;
      bus.lsu_rdata   = w;
   endtask

   initial begin
      bit acc;
      int waits;
      logic [2:0] legal [5];
      legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;
      mbusy = '0;
      merr  = 0;
      idle();
      rest = 1'b1;
      step(acc);
      step(acc);
      rest = 1'b0;
      chk("reset_busy", bus.busy, 32'd0);

      // ALU result lands one cycle later
      idle(); bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
      step(acc);
      chk("t1_rd_dt", bus.rd_dt, 32'h1234);

      // byte and halfword extension
      idle(); load(5'd1, 3'd0, 2'd3, 32'h80FF_0000); step(acc);
      chk("t2_lb", bus.rd_dt, 32'hFFFF_FF80);
      idle(); load(5'd1, 3'd4, 2'd3, 32'h80FF_0000); step(acc);
      chk("t2_lbu", bus.rd_dt, 32'h0000_0080);
      idle(); load(5'd2, 3'd1, 2'd2, 32'h8001_7FFF); step(acc);
      chk("t3_lh", bus.rd_dt, 32'hFFFF_8001);
      idle(); load(5'd2, 3'd5, 2'd3, 32'h8001_7FFF); step(acc);
      chk("t3_lhu", bus.rd_dt, 32'h0000_8001);
      idle(); load(5'd3, 3'd3, 2'd0, 32'hDEAD_BEEF); step(acc);
      chk("illegal_data", bus.rd_dt, 32'd0);
      chk("illegal_err", 32'(bus.err_funct3), 32'd1);
      idle(); step(acc);

      // ALU burst while three loads arrive; the third waits for space
      idle(); bus.issue_valid = 1; bus.issue_rd = 5'd10; step(acc);
      bus.issue_rd = 5'd11; step(acc);
      bus.issue_rd = 5'd12; step(acc);
      idle();
      for (int n = 0; n < 3; n++) begin
         load(5'(10 + n), 3'd2, 2'd0, 32'hA000_0000 + 32'(n));
         waits = 0;
         do begin
            bus.alu_valid = (waits < 4) && (n < 2 || waits < 2);
            bus.alu_rd    = 5'(20 + waits);
            bus.alu_data  = 32'h5500_0000 + 32'(waits);
            step(acc);
            waits++;
         end while (!acc && waits < 20);
         chk("t4_accept_bound", 32'(acc), 32'd1);
      end
      idle();
      for (int n = 0; n < 4; n++) step(acc);
      chk("t4_busy_clear", bus.busy & 32'h0000_1C00, 32'd0);

      // set wins over clear; rd=0 ALU produces no write
      idle(); bus.issue_valid = 1; bus.issue_rd = 5'd7; step(acc);
      idle(); bus.issue_valid = 1; bus.issue_rd = 5'd7; load(5'd7, 3'd2, 2'd0, 32'h7777_7777); step(acc);
      chk("t5_busy7", 32'(bus.busy[7]), 32'd1);
      idle(); bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFF_FFFF; step(acc);
      chk("t5_x0_we", 32'(bus.we), 32'd0);

      // reset with two queued loads
      idle(); bus.issue_valid = 1; bus.issue_rd = 5'd9; step(acc);
      bus.issue_valid = 0;
      bus.alu_valid = 1; bus.alu_rd = 5'd4; load(5'd8, 3'd2, 2'd0, 32'h1111_1111); step(acc);
      load(5'd9, 3'd2, 2'd0, 32'h2222_2222); step(acc);
      idle(); rest = 1'b1; step(acc);
      chk("t6_busy", bus.busy, 32'd0);
      rest = 1'b0;
      step(acc);
      chk("t6_no_write", 32'(bus.we), 32'd0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         idle();
         rest = ($urandom_range(0, 99) < 2);
         bus.alu_valid   = ($urandom_range(0, 9) < 4);
         bus.alu_rd      = 5'($urandom);
         bus.alu_data    = $urandom;
         bus.issue_valid = ($urandom_range(0, 9) < 3);
         bus.issue_rd    = 5'($urandom);
         if ($urandom_range(0, 9) < 5)
            load(5'($urandom),
                 ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom),
                 2'($urandom), $urandom);
         step(acc);
      end
      rest = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
